// File: rtl/led_frame_ctrl.sv
// LED panel frame controller: gates the driver through OFF/RESET/RUN, validates and
// stages software config, and swaps display buffers at driver frame boundaries.
module led_frame_ctrl #(
  parameter int N_ROWS_MAX     = 64,
  parameter int N_COLS_MAX     = 256,
  parameter int BITDEPTH_MAX   = 8,
  parameter int LSB_BLANK_MAX  = 200,
  parameter int CTRL_REG_WIDTH = 32,
  parameter int RST_CYCLES     = 4
) (
  input  logic                      clk,
  input  logic                      ctrl_rst,
  input  logic                      sw_en,
  input  logic [CTRL_REG_WIDTH-1:0] sw_n_rows,
  input  logic [CTRL_REG_WIDTH-1:0] sw_n_cols,
  input  logic [CTRL_REG_WIDTH-1:0] sw_bitdepth,
  input  logic [CTRL_REG_WIDTH-1:0] sw_lsb_blank,
  input  logic [CTRL_REG_WIDTH-1:0] sw_brightness,
  input  logic                      sw_cfg_commit,
  input  logic                      sw_swap_req,
  input  logic                      irq_ack,
  input  logic                      drv_frame_sync,
  output logic                      drv_en,
  output logic                      drv_rst,
  output logic [CTRL_REG_WIDTH-1:0] drv_n_rows,
  output logic [CTRL_REG_WIDTH-1:0] drv_n_cols,
  output logic [CTRL_REG_WIDTH-1:0] drv_bitdepth,
  output logic [CTRL_REG_WIDTH-1:0] drv_lsb_blank,
  output logic [CTRL_REG_WIDTH-1:0] drv_brightness,
  output logic                      drv_buffer,
  output logic                      wr_buffer,
  output logic                      swap_pending,
  output logic                      cfg_pending,
  output logic                      cfg_err,
  output logic                      irq_swap_done,
  output logic [15:0]               frame_count
);

  localparam int W  = CTRL_REG_WIDTH;
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_RESET = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [W-1:0]  ROWS_MAX  = W'(N_ROWS_MAX);
  localparam logic [W-1:0]  COLS_MAX  = W'(N_COLS_MAX);
  localparam logic [W-1:0]  BD_MAX    = W'(BITDEPTH_MAX);
  localparam logic [W-1:0]  BLANK_MAX = W'(LSB_BLANK_MAX);
  localparam logic [CW-1:0] CNT_LAST  = CW'(RST_CYCLES - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] rst_cnt;
  logic          cfg_loaded;

  logic [W-1:0]  pend_n_rows;
  logic [W-1:0]  pend_n_cols;
  logic [W-1:0]  pend_bitdepth;
  logic [W-1:0]  pend_lsb_blank;
  logic [W-1:0]  pend_brightness;

  logic commit_ok;
  logic commit_vld;
  logic off_load;
  logic sync_run;
  logic cfg_apply;
  logic swap_apply;

  always_comb begin
    commit_ok = (sw_n_rows[0] == 1'b0) && (sw_n_rows >= W'(2)) && (sw_n_rows <= ROWS_MAX) &&
                (sw_n_cols >= W'(1)) && (sw_n_cols <= COLS_MAX) &&
                (sw_bitdepth >= W'(1)) && (sw_bitdepth <= BD_MAX) &&
                (sw_lsb_blank >= W'(1)) && (sw_lsb_blank <= BLANK_MAX) &&
                (sw_brightness < sw_lsb_blank);
  end

  assign commit_vld = sw_cfg_commit && commit_ok;
  assign off_load   = commit_vld && (state == ST_OFF);
  assign sync_run   = drv_frame_sync && (state == ST_RUN);
  assign cfg_apply  = sync_run && cfg_pending;
  assign swap_apply = sync_run && swap_pending;
  assign wr_buffer  = ~drv_buffer;

  // Driver may only leave OFF once some config has actually reached it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:   if (cfg_loaded) state_nxt = ST_RESET;
      ST_RESET: if (rst_cnt == CNT_LAST) state_nxt = ST_RUN;
      ST_RUN:   if (cfg_apply) state_nxt = ST_RESET;
      default:  state_nxt = ST_OFF;
    endcase
    if (!sw_en) state_nxt = ST_OFF;
  end

  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      state   <= ST_OFF;
      rst_cnt <= '0;
      drv_en  <= 1'b0;
      drv_rst <= 1'b1;
    end else begin
      state   <= state_nxt;
      rst_cnt <= (state == ST_RESET) ? rst_cnt + CW'(1) : '0;
      drv_en  <= (state_nxt == ST_RUN);
      drv_rst <= (state_nxt != ST_RUN);
    end
  end

  // Active config: loaded directly from software while OFF, else only at a frame boundary.
  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      drv_n_rows     <= ROWS_MAX;
      drv_n_cols     <= COLS_MAX;
      drv_bitdepth   <= BD_MAX;
      drv_lsb_blank  <= BLANK_MAX;
      drv_brightness <= '0;
      cfg_loaded     <= 1'b0;
    end else if (off_load) begin
      drv_n_rows     <= sw_n_rows;
      drv_n_cols     <= sw_n_cols;
      drv_bitdepth   <= sw_bitdepth;
      drv_lsb_blank  <= sw_lsb_blank;
      drv_brightness <= sw_brightness;
      cfg_loaded     <= 1'b1;
    end else if (cfg_apply) begin
      drv_n_rows     <= pend_n_rows;
      drv_n_cols     <= pend_n_cols;
      drv_bitdepth   <= pend_bitdepth;
      drv_lsb_blank  <= pend_lsb_blank;
      drv_brightness <= pend_brightness;
    end
  end

  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      pend_n_rows     <= '0;
      pend_n_cols     <= '0;
      pend_bitdepth   <= '0;
      pend_lsb_blank  <= '0;
      pend_brightness <= '0;
      cfg_pending     <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      if (commit_vld) begin
        pend_n_rows     <= sw_n_rows;
        pend_n_cols     <= sw_n_cols;
        pend_bitdepth   <= sw_bitdepth;
        pend_lsb_blank  <= sw_lsb_blank;
        pend_brightness <= sw_brightness;
      end
      if (sw_cfg_commit) cfg_err <= !commit_ok;
      // A commit landing on the apply cycle stays pending for the next frame.
      if (commit_vld && (state != ST_OFF)) cfg_pending <= 1'b1;
      else if (cfg_apply || off_load)      cfg_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      drv_buffer    <= 1'b0;
      swap_pending  <= 1'b0;
      irq_swap_done <= 1'b0;
      frame_count   <= '0;
    end else begin
      if (swap_apply) drv_buffer <= ~drv_buffer;
      swap_pending <= sw_swap_req || (swap_pending && !swap_apply);
      if (swap_apply)   irq_swap_done <= 1'b1;
      else if (irq_ack) irq_swap_done <= 1'b0;
      if (sync_run) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed bench for led_frame_ctrl: bring-up, swaps, collisions, config validation,
// live reconfig, counter wrap and asynchronous reset.
module tb_led_frame_ctrl;

  logic        clk = 1'b0;
  logic        ctrl_rst = 1'b1;
  logic        sw_en = 1'b0;
  logic [31:0] sw_n_rows = '0;
  logic [31:0] sw_n_cols = '0;
  logic [31:0] sw_bitdepth = '0;
  logic [31:0] sw_lsb_blank = '0;
  logic [31:0] sw_brightness = '0;
  logic        sw_cfg_commit = 1'b0;
  logic        sw_swap_req = 1'b0;
  logic        irq_ack = 1'b0;
  logic        drv_frame_sync = 1'b0;
  logic        drv_en, drv_rst;
  logic [31:0] drv_n_rows, drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness;
  logic        drv_buffer, wr_buffer, swap_pending, cfg_pending, cfg_err, irq_swap_done;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]   flags;
  logic [159:0] cfg;
  assign flags = {drv_en, drv_rst, drv_buffer, wr_buffer, swap_pending, cfg_pending, cfg_err, irq_swap_done};
  assign cfg   = {drv_n_rows, drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness};

  always #5 clk = ~clk;

  led_frame_ctrl dut (
    .clk(clk), .ctrl_rst(ctrl_rst), .sw_en(sw_en),
    .sw_n_rows(sw_n_rows), .sw_n_cols(sw_n_cols), .sw_bitdepth(sw_bitdepth),
    .sw_lsb_blank(sw_lsb_blank), .sw_brightness(sw_brightness),
    .sw_cfg_commit(sw_cfg_commit), .sw_swap_req(sw_swap_req), .irq_ack(irq_ack),
    .drv_frame_sync(drv_frame_sync), .drv_en(drv_en), .drv_rst(drv_rst),
    .drv_n_rows(drv_n_rows), .drv_n_cols(drv_n_cols), .drv_bitdepth(drv_bitdepth),
    .drv_lsb_blank(drv_lsb_blank), .drv_brightness(drv_brightness),
    .drv_buffer(drv_buffer), .wr_buffer(wr_buffer), .swap_pending(swap_pending),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .irq_swap_done(irq_swap_done),
    .frame_count(frame_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] r, input logic [31:0] c, input logic [31:0] b,
                        input logic [31:0] l, input logic [31:0] br);
    sw_n_rows = r; sw_n_cols = c; sw_bitdepth = b; sw_lsb_blank = l; sw_brightness = br;
    sw_cfg_commit = 1'b1;
    tick();
    sw_cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    ctrl_rst = 1'b1;
    tick(); tick();
    checks++; if (flags !== 8'b0101_0000) begin errors++; $display("FAIL reset_flags: got %b want %b", flags, 8'b0101_0000); end
    checks++; if (cfg !== {32'd64, 32'd256, 32'd8, 32'd200, 32'd0}) begin errors++; $display("FAIL reset_cfg: got %h", cfg); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_fc: got %h want 0", frame_count); end
    ctrl_rst = 1'b0;
    tick();
    sw_en = 1'b1;
    repeat (3) tick();
    checks++; if ({drv_en, drv_rst} !== 2'b01) begin errors++; $display("FAIL noconfig_stays_off: got %b want 01", {drv_en, drv_rst}); end
    sw_en = 1'b0;
    tick();
  endtask

  task automatic test_bringup();
    commit(32'd64, 32'd256, 32'd8, 32'd100, 32'd10);
    checks++; if (cfg !== {32'd64, 32'd256, 32'd8, 32'd100, 32'd10}) begin errors++; $display("FAIL bringup_cfg: got %h", cfg); end
    checks++; if (flags !== 8'b0101_0000) begin errors++; $display("FAIL bringup_off_flags: got %b want %b", flags, 8'b0101_0000); end
    sw_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({drv_en, drv_rst} !== 2'b01) begin errors++; $display("FAIL bringup_rst_cycle%0d: got %b want 01", i, {drv_en, drv_rst}); end
      tick();
    end
    checks++; if ({drv_en, drv_rst} !== 2'b10) begin errors++; $display("FAIL bringup_run: got %b want 10", {drv_en, drv_rst}); end
  endtask

  task automatic test_swap();
    sw_swap_req = 1'b1; tick(); sw_swap_req = 1'b0;
    checks++; if (flags !== 8'b1001_1000) begin errors++; $display("FAIL swap_req_flags: got %b want %b", flags, 8'b1001_1000); end
    drv_frame_sync = 1'b1; tick(); drv_frame_sync = 1'b0;
    checks++; if (flags !== 8'b1010_0001) begin errors++; $display("FAIL swap_done_flags: got %b want %b", flags, 8'b1010_0001); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL swap_fc: got %0d want 1", frame_count); end
    tick(); tick();
    checks++; if (irq_swap_done !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", irq_swap_done); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (irq_swap_done !== 1'b0) begin errors++; $display("FAIL irq_ack_clear: got %b want 0", irq_swap_done); end
  endtask

  task automatic test_collision();
    drv_frame_sync = 1'b1; sw_swap_req = 1'b1; tick(); drv_frame_sync = 1'b0; sw_swap_req = 1'b0;
    checks++; if (flags !== 8'b1010_1000) begin errors++; $display("FAIL coll_no_toggle: got %b want %b", flags, 8'b1010_1000); end
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL coll_fc: got %0d want 2", frame_count); end
    drv_frame_sync = 1'b1; irq_ack = 1'b1; tick(); drv_frame_sync = 1'b0; irq_ack = 1'b0;
    checks++; if (flags !== 8'b1001_0001) begin errors++; $display("FAIL coll_toggle_irq_wins: got %b want %b", flags, 8'b1001_0001); end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL coll_fc2: got %0d want 3", frame_count); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    checks++; if (irq_swap_done !== 1'b0) begin errors++; $display("FAIL coll_irq_clear: got %b want 0", irq_swap_done); end
  endtask

  task automatic test_invalid_cfg();
    commit(32'd63, 32'd256, 32'd8, 32'd100, 32'd10);
    checks++; if (flags !== 8'b1001_0010) begin errors++; $display("FAIL bad_rows_flags: got %b want %b", flags, 8'b1001_0010); end
    checks++; if (cfg !== {32'd64, 32'd256, 32'd8, 32'd100, 32'd10}) begin errors++; $display("FAIL bad_rows_cfg: got %h", cfg); end
    commit(32'd64, 32'd256, 32'd8, 32'd100, 32'd100);
    checks++; if (flags !== 8'b1001_0010) begin errors++; $display("FAIL bad_bright_flags: got %b want %b", flags, 8'b1001_0010); end
    checks++; if (drv_brightness !== 32'd10) begin errors++; $display("FAIL bad_bright_cfg: got %0d want 10", drv_brightness); end
    commit(32'd64, 32'd257, 32'd8, 32'd100, 32'd10);
    checks++; if (flags !== 8'b1001_0010) begin errors++; $display("FAIL bad_cols_flags: got %b want %b", flags, 8'b1001_0010); end
    commit(32'd64, 32'd128, 32'd8, 32'd100, 32'd10);
    checks++; if (flags !== 8'b1001_0100) begin errors++; $display("FAIL good_commit_flags: got %b want %b", flags, 8'b1001_0100); end
    checks++; if (drv_n_cols !== 32'd256) begin errors++; $display("FAIL good_commit_not_live: got %0d want 256", drv_n_cols); end
  endtask

  task automatic test_live_reconfig();
    sw_swap_req = 1'b1; tick(); sw_swap_req = 1'b0;
    checks++; if (flags !== 8'b1001_1100) begin errors++; $display("FAIL live_pending: got %b want %b", flags, 8'b1001_1100); end
    drv_frame_sync = 1'b1; tick(); drv_frame_sync = 1'b0;
    checks++; if (flags !== 8'b0110_0001) begin errors++; $display("FAIL live_apply_flags: got %b want %b", flags, 8'b0110_0001); end
    checks++; if (cfg !== {32'd64, 32'd128, 32'd8, 32'd100, 32'd10}) begin errors++; $display("FAIL live_cfg: got %h", cfg); end
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL live_fc: got %0d want 4", frame_count); end
    drv_frame_sync = 1'b1; tick(); drv_frame_sync = 1'b0;
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL sync_in_reset_ignored: got %0d want 4", frame_count); end
    for (int i = 1; i < 4; i++) begin
      if (i > 1) tick();
      checks++; if ({drv_en, drv_rst} !== 2'b01) begin errors++; $display("FAIL live_rst_cycle%0d: got %b want 01", i, {drv_en, drv_rst}); end
    end
    tick();
    checks++; if ({drv_en, drv_rst} !== 2'b10) begin errors++; $display("FAIL live_run: got %b want 10", {drv_en, drv_rst}); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic test_sw_en_off();
    sw_en = 1'b0; tick();
    checks++; if (flags !== 8'b0110_0000) begin errors++; $display("FAIL off_flags: got %b want %b", flags, 8'b0110_0000); end
    drv_frame_sync = 1'b1; tick(); drv_frame_sync = 1'b0;
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL off_sync_ignored: got %0d want 4", frame_count); end
    checks++; if (drv_n_cols !== 32'd128) begin errors++; $display("FAIL off_cfg_kept: got %0d want 128", drv_n_cols); end
    sw_en = 1'b1;
    repeat (5) tick();
    checks++; if ({drv_en, drv_rst} !== 2'b10) begin errors++; $display("FAIL reenable_run: got %b want 10", {drv_en, drv_rst}); end
  endtask

  task automatic test_wrap();
    drv_frame_sync = 1'b1;
    repeat (65531) tick();
    drv_frame_sync = 1'b0;
    checks++; if (frame_count !== 16'hFFFF) begin errors++; $display("FAIL fc_max: got %h want ffff", frame_count); end
    drv_frame_sync = 1'b1; tick(); drv_frame_sync = 1'b0;
    checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL fc_wrap: got %h want 0000", frame_count); end
    drv_frame_sync = 1'b1; tick(); tick(); drv_frame_sync = 1'b0;
    checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL fc_after_wrap: got %h want 0002", frame_count); end
  endtask

  task automatic test_reset_mid();
    sw_en = 1'b0; tick();
    sw_en = 1'b1; sw_swap_req = 1'b1; tick(); sw_swap_req = 1'b0;
    commit(32'd32, 32'd64, 32'd4, 32'd50, 32'd20);
    checks++; if (flags !== 8'b0110_1100) begin errors++; $display("FAIL pre_reset_flags: got %b want %b", flags, 8'b0110_1100); end
    #2 ctrl_rst = 1'b1;
    #1;
    checks++; if (flags !== 8'b0101_0000) begin errors++; $display("FAIL async_reset_flags: got %b want %b", flags, 8'b0101_0000); end
    checks++; if (cfg !== {32'd64, 32'd256, 32'd8, 32'd200, 32'd0}) begin errors++; $display("FAIL async_reset_cfg: got %h", cfg); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL async_reset_fc: got %h want 0", frame_count); end
    tick();
    ctrl_rst = 1'b0;
    repeat (6) tick();
    checks++; if ({drv_en, drv_rst} !== 2'b01) begin errors++; $display("FAIL loaded_flag_cleared: got %b want 01", {drv_en, drv_rst}); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_swap();
    test_collision();
    test_invalid_cfg();
    test_live_reconfig();
    test_sw_en_off();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
